prf_wr_arbiter: RTL and testbench
=================================

# prf_wr_arbiter

Arbitrates the 7 physical-register-file writeback requesters onto the 4 single-write-port PRF banks. Each requester owns a one-entry holding buffer. Each bank has an independent round-robin arbiter. Winners are registered onto the per-bank write ports, which also serve as the writeback/wakeup broadcast. The block sits between the execution-unit writeback stages and the banked PRF in the central datapath.

## Interface
- PRF_WR_COUNT, 7, number of writeback requesters
- PRF_BANK_COUNT, 4, number of PRF banks (power of two)
- LOG_PRF_BANK_COUNT, 2, bank select width
- LOG_PR_COUNT, 7, physical register index width
- XLEN, 32, data width

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  reset, asynchronous, active-high
- wr_req_valid  in  [PRF_WR_COUNT]  requester i presents a write
- wr_req_PR  in  [PRF_WR_COUNT][LOG_PR_COUNT]  destination physical register
- wr_req_data  in  [PRF_WR_COUNT][XLEN]  write data
- wr_req_ready  out  [PRF_WR_COUNT]  requester i may transfer this cycle
- bank_wr_valid  out  [PRF_BANK_COUNT]  bank b write-port enable
- bank_wr_upper_PR  out  [PRF_BANK_COUNT][LOG_PR_COUNT-LOG_PRF_BANK_COUNT]  row index within bank
- bank_wr_data  out  [PRF_BANK_COUNT][XLEN]  write data
- bank_wr_src  out  [PRF_BANK_COUNT][PRF_WR_COUNT]  one-hot granted requester (debug/perf)

## Operation
- Bank of a PR = PR[LOG_PRF_BANK_COUNT-1:0]. Row = PR[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT].
- Transfer: wr_req_valid[i] && wr_req_ready[i] at a rising edge loads buffer i with {PR, data} and sets buf_valid[i].
- PR 0 is hardwired zero. A request to PR 0 with ready high is consumed (counts as transferred), is not buffered, and is never written.
- Per bank b: candidates are buffered entries with bank == b. The grant is round-robin: priority starts at rr_ptr[b] and scans upward modulo PRF_WR_COUNT.
- On a grant to requester g for bank b at an edge:
  - bank b output registers load g's row, data and one-hot src, and bank_wr_valid[b] is set.
  - buf_valid[g] clears unless a new transfer loads it on the same edge.
  - rr_ptr[b] becomes (g+1) mod PRF_WR_COUNT.
- A bank with no candidate drives bank_wr_valid[b]=0 next cycle. Its rr_ptr and its data/PR registers hold their values.
- wr_req_ready[i] = !buf_valid[i] || granted[i]. This is combinational from buffer state only, never from wr_req_valid, so there is no valid-to-ready loop.
- At most one grant per requester per cycle (each buffer targets exactly one bank). Up to 4 grants per cycle total.
- Reset, asynchronous and immediate, including mid-operation:
  - all buf_valid=0 and all rr_ptr=0.
  - bank_wr_valid=0, bank_wr_upper_PR=0, bank_wr_data=0, bank_wr_src=0.
  - wr_req_ready therefore reads all-ones during and after reset.
  - Any buffered writes are dropped.

## Timing
- A request transferred at edge E0 is arbitrated during the cycle after E0 and appears on bank_wr_* after edge E1 at the earliest. The write is visible for the cycle following E1. Minimum latency is 2 edges from request valid to write-port valid.
- Throughput: 1 write per bank per cycle. Under no conflict a requester sustains 1 transfer per cycle, because ready stays high while its buffer is granted each cycle.
- Conflict: N buffers on one bank drain in N consecutive cycles in round-robin order. Losers see ready=0 until granted.
- bank_wr_* are registered with no combinational path from inputs.

## Structure
- Take PRF_WR_COUNT, PRF_BANK_COUNT, LOG_PRF_BANK_COUNT, LOG_PR_COUNT and XLEN from core_types_pkg. Nothing new is added to the package.
- One sub-module: rr_arbiter (parameter REQ_COUNT; inputs req vector and ptr; output one-hot grant). Instantiate it once per bank.

## Test plan
- Reset with requests asserted -> all ready=1, bank_wr_valid=0 through reset. First requests after deassert transfer normally.
- Requesters 0..3 write PR 4,9,14,19 (banks 0,1,2,3) in the same cycle -> two edges later all four bank_wr_valid=1, rows 1,2,3,4, correct data, src one-hot 0..3.
- All 7 requesters write bank 2 (PR 2,6,10,...,26) at once -> writes emerge on bank 2 on 7 consecutive cycles in order 0,1,...,6. Each requester's ready is low until its own grant.
- Requester 3 streams 10 back-to-back writes to bank 1 with no contention -> ready stays 1 and bank 1 is valid for 10 consecutive cycles, in order.
- Grant to requester 5 on bank 0, then requesters 2 and 6 contend on bank 0 -> 6 is granted before 2.
- Write to PR 0 -> ready=1, no bank write ever issued. Assert RST while 3 buffers are full -> outputs clear immediately and no stale write appears afterward.

Source files
------------

// File: rtl/core_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_types_pkg
//  Brief    : Core-wide sizing constants shared by the central datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package core_types_pkg;

    localparam int PRF_WR_COUNT       = 7;
    localparam int PRF_BANK_COUNT     = 4;
    localparam int LOG_PRF_BANK_COUNT = 2;
    localparam int LOG_PR_COUNT       = 7;
    localparam int XLEN               = 32;

endpackage : core_types_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin arbiter. Priority starts at ptr and
//             scans upward modulo REQ_COUNT; output grant is one-hot or zero.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int REQ_COUNT = 7,
    parameter int PTR_W     = $clog2(REQ_COUNT)
) (
    input  logic [REQ_COUNT-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [REQ_COUNT-1:0] grant
);

    // Scan from ptr upward with wrap; the first requester found wins.
    always_comb begin
        logic             v_found;
        logic [PTR_W:0]   v_sum;
        logic [PTR_W-1:0] v_idx;
        grant   = '0;
        v_found = 1'b0;
        v_sum   = '0;
        v_idx   = '0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            // ptr is always below REQ_COUNT, so a single wrap subtraction suffices
            v_sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (v_sum >= (PTR_W+1)'(REQ_COUNT)) begin
                v_sum = v_sum - (PTR_W+1)'(REQ_COUNT);
            end
            v_idx = v_sum[PTR_W-1:0];
            if (!v_found && req[v_idx]) begin
                grant[v_idx] = 1'b1;
                v_found      = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/prf_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : prf_wr_arbiter
//  Brief    : Arbitrates the PRF writeback requesters onto the banked PRF
//             write ports. One-entry holding buffer per requester, one
//             round-robin arbiter per bank, registered write/wakeup ports.
//  Revision : 1.0 - initial release
// ============================================================================
module prf_wr_arbiter
    import core_types_pkg::*;
(
    input  logic                                                         CLK,
    input  logic                                                         RST,
    input  logic [PRF_WR_COUNT-1:0]                                      wr_req_valid,
    input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]                    wr_req_PR,
    input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]                            wr_req_data,
    output logic [PRF_WR_COUNT-1:0]                                      wr_req_ready,
    output logic [PRF_BANK_COUNT-1:0]                                    bank_wr_valid,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] bank_wr_upper_PR,
    output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]                          bank_wr_data,
    output logic [PRF_BANK_COUNT-1:0][PRF_WR_COUNT-1:0]                  bank_wr_src
);

    localparam int c_PTR_W = $clog2(PRF_WR_COUNT);
    localparam int c_ROW_W = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

    // Holding buffers, one per requester
    logic [PRF_WR_COUNT-1:0] r_buf_valid;
    logic [LOG_PR_COUNT-1:0] r_buf_pr   [PRF_WR_COUNT];
    logic [XLEN-1:0]         r_buf_data [PRF_WR_COUNT];

    // Per-bank round-robin pointers
    logic [c_PTR_W-1:0]      r_rr_ptr   [PRF_BANK_COUNT];

    logic [PRF_WR_COUNT-1:0] w_bank_req   [PRF_BANK_COUNT];
    logic [PRF_WR_COUNT-1:0] w_bank_grant [PRF_BANK_COUNT];
    logic [PRF_BANK_COUNT-1:0] w_any_grant;
    logic [c_PTR_W-1:0]      w_grant_idx  [PRF_BANK_COUNT];
    logic [c_PTR_W-1:0]      w_next_ptr   [PRF_BANK_COUNT];
    logic [c_ROW_W-1:0]      w_grant_row  [PRF_BANK_COUNT];
    logic [XLEN-1:0]         w_grant_data [PRF_BANK_COUNT];
    logic [PRF_WR_COUNT-1:0] w_granted;
    logic [PRF_WR_COUNT-1:0] w_transfer;

    // Route each valid buffer to the request vector of the bank its PR lives in.
    always_comb begin
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            w_bank_req[b] = '0;
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                w_bank_req[b][i] = r_buf_valid[i] &&
                    (r_buf_pr[i][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b));
            end
        end
    end

    generate
        for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank_arb
            rr_arbiter #(
                .REQ_COUNT (PRF_WR_COUNT),
                .PTR_W     (c_PTR_W)
            ) u_rr_arbiter (
                .req   (w_bank_req[b]),
                .ptr   (r_rr_ptr[b]),
                .grant (w_bank_grant[b])
            );
        end
    endgenerate

    // Decode each bank's one-hot grant into index, row and data of the winner.
    always_comb begin
        w_granted = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            w_any_grant[b]  = |w_bank_grant[b];
            w_grant_idx[b]  = '0;
            w_grant_row[b]  = '0;
            w_grant_data[b] = '0;
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                if (w_bank_grant[b][i]) begin
                    w_grant_idx[b]  = c_PTR_W'(i);
                    w_grant_row[b]  = r_buf_pr[i][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
                    w_grant_data[b] = r_buf_data[i];
                end
            end
            w_next_ptr[b] = (w_grant_idx[b] == c_PTR_W'(PRF_WR_COUNT-1)) ?
                            '0 : w_grant_idx[b] + 1'b1;
            w_granted = w_granted | w_bank_grant[b];
        end
    end

    // Ready depends only on buffer state, so there is no valid-to-ready path.
    assign wr_req_ready = ~r_buf_valid | w_granted;
    assign w_transfer   = wr_req_valid & wr_req_ready;

    // Buffer load/drain; PR 0 transfers are consumed without being buffered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_buf_valid <= '0;
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                r_buf_pr[i]   <= '0;
                r_buf_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                if (w_transfer[i] && (wr_req_PR[i] != '0)) begin
                    r_buf_valid[i] <= 1'b1;
                    r_buf_pr[i]    <= wr_req_PR[i];
                    r_buf_data[i]  <= wr_req_data[i];
                end else if (w_granted[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Register bank write ports and advance each bank's pointer past its winner.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bank_wr_valid    <= '0;
            bank_wr_upper_PR <= '0;
            bank_wr_data     <= '0;
            bank_wr_src      <= '0;
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                r_rr_ptr[b] <= '0;
            end
        end else begin
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                if (w_any_grant[b]) begin
                    bank_wr_valid[b]    <= 1'b1;
                    bank_wr_upper_PR[b] <= w_grant_row[b];
                    bank_wr_data[b]     <= w_grant_data[b];
                    bank_wr_src[b]      <= w_bank_grant[b];
                    r_rr_ptr[b]         <= w_next_ptr[b];
                end else begin
                    bank_wr_valid[b]    <= 1'b0;
                end
            end
        end
    end

endmodule : prf_wr_arbiter
`default_nettype wire

// File: tb/tb_prf_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prf_wr_arbiter
//  Brief    : Self-checking bench for prf_wr_arbiter with a per-bank
//             scoreboard of expected writes tagged with their due cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prf_wr_arbiter;
    import core_types_pkg::*;

    localparam int W  = PRF_WR_COUNT;
    localparam int NB = PRF_BANK_COUNT;
    localparam int RW = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

    logic                              CLK;
    logic                              RST;
    logic [W-1:0]                      wr_req_valid;
    logic [W-1:0][LOG_PR_COUNT-1:0]    wr_req_PR;
    logic [W-1:0][XLEN-1:0]            wr_req_data;
    logic [W-1:0]                      wr_req_ready;
    logic [NB-1:0]                     bank_wr_valid;
    logic [NB-1:0][RW-1:0]             bank_wr_upper_PR;
    logic [NB-1:0][XLEN-1:0]           bank_wr_data;
    logic [NB-1:0][W-1:0]              bank_wr_src;

    typedef struct {
        int              due;
        logic [RW-1:0]   row;
        logic [XLEN-1:0] data;
        logic [W-1:0]    src;
    } exp_t;

    exp_t exp_q [NB][$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    prf_wr_arbiter dut (
        .CLK              (CLK),
        .RST              (RST),
        .wr_req_valid     (wr_req_valid),
        .wr_req_PR        (wr_req_PR),
        .wr_req_data      (wr_req_data),
        .wr_req_ready     (wr_req_ready),
        .bank_wr_valid    (bank_wr_valid),
        .bank_wr_upper_PR (bank_wr_upper_PR),
        .bank_wr_data     (bank_wr_data),
        .bank_wr_src      (bank_wr_src)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard: each bank must write exactly its queued entries on their due cycles.
    always @(negedge CLK) begin
        if (!RST) begin
            for (int b = 0; b < NB; b++) begin
                if (exp_q[b].size() > 0 && exp_q[b][0].due <= cyc) begin
                    mon_e = exp_q[b].pop_front();
                    n_cmp++;
                    if (mon_e.due != cyc || bank_wr_valid[b] !== 1'b1 ||
                        bank_wr_upper_PR[b] !== mon_e.row ||
                        bank_wr_data[b] !== mon_e.data || bank_wr_src[b] !== mon_e.src) begin
                        n_err++;
                        $display("FAIL bank%0d_write cyc=%0d: got v=%b row=%0d data=%h src=%b, want v=1 row=%0d data=%h src=%b due=%0d",
                                 b, cyc, bank_wr_valid[b], bank_wr_upper_PR[b], bank_wr_data[b],
                                 bank_wr_src[b], mon_e.row, mon_e.data, mon_e.src, mon_e.due);
                    end
                end else if (bank_wr_valid[b] !== 1'b0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL bank%0d_unexpected cyc=%0d: got valid=%b row=%0d data=%h src=%b, want valid=0",
                             b, cyc, bank_wr_valid[b], bank_wr_upper_PR[b], bank_wr_data[b], bank_wr_src[b]);
                end
            end
        end
    end

    // Present a request on requester i; k is its expected position in its bank's drain order.
    task automatic put_req(input int i, input logic [LOG_PR_COUNT-1:0] pr,
                           input logic [XLEN-1:0] d, input int k);
        exp_t e;
        wr_req_valid[i] = 1'b1;
        wr_req_PR[i]    = pr;
        wr_req_data[i]  = d;
        if (pr != '0) begin
            e.due  = cyc + 2 + k;
            e.row  = pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
            e.data = d;
            e.src  = W'(1) << i;
            exp_q[int'(pr[LOG_PRF_BANK_COUNT-1:0])].push_back(e);
        end
    endtask

    task automatic clear_q();
        for (int b = 0; b < NB; b++) exp_q[b].delete();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST          = 1'b1;
        wr_req_valid = '0;
        clear_q();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Wait (bounded) for all expected writes, then idle to catch stray writes.
    task automatic drain(input string name);
        int pending;
        pending = 1;
        for (int t = 0; t < 40 && pending != 0; t++) begin
            @(negedge CLK);
            #1;
            pending = 0;
            for (int b = 0; b < NB; b++) pending += exp_q[b].size();
        end
        n_cmp++;
        if (pending != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d writes outstanding, want 0", name, pending);
            clear_q();
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST          = 1'b1;
        wr_req_valid = '1;
        for (int i = 0; i < W; i++) begin
            wr_req_PR[i]   = LOG_PR_COUNT'(i + 1);
            wr_req_data[i] = 32'hDEAD_0000 + i;
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge CLK);
            #1;
            n_cmp++;
            if (wr_req_ready !== '1 || bank_wr_valid !== '0 || bank_wr_upper_PR !== '0 ||
                bank_wr_data !== '0 || bank_wr_src !== '0) begin
                n_err++;
                $display("FAIL reset_state: got ready=%b valid=%b row=%h data=%h src=%h, want ready=1111111 all else 0",
                         wr_req_ready, bank_wr_valid, bank_wr_upper_PR, bank_wr_data, bank_wr_src);
            end
        end
        @(negedge CLK);
        RST          = 1'b0;
        wr_req_valid = '0;
        @(negedge CLK);
        n_cmp++;
        if (wr_req_ready !== '1) begin
            n_err++;
            $display("FAIL reset_ready_after: got %b, want 1111111", wr_req_ready);
        end
        put_req(0, 7'd4, 32'hA5A5_0001, 0);
        @(negedge CLK);
        wr_req_valid = '0;
        drain("reset_first_req");
    endtask

    task automatic test_four_banks();
        do_reset();
        put_req(0, 7'd4,  32'h1000_0000, 0);
        put_req(1, 7'd9,  32'h1111_1111, 0);
        put_req(2, 7'd14, 32'h2222_2222, 0);
        put_req(3, 7'd19, 32'h3333_3333, 0);
        @(negedge CLK);
        wr_req_valid = '0;
        drain("four_banks");
    endtask

    task automatic test_bank_conflict();
        logic [W-1:0] exp_rdy;
        do_reset();
        for (int i = 0; i < W; i++) put_req(i, LOG_PR_COUNT'(2 + 4 * i), 32'hC0DE_0000 + i, i);
        @(negedge CLK);
        wr_req_valid = '0;
        for (int k = 0; k < W; k++) begin
            #1;
            exp_rdy = W'((1 << (k + 1)) - 1);
            n_cmp++;
            if (wr_req_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL conflict_ready_%0d: got %b, want %b", k, wr_req_ready, exp_rdy);
            end
            @(negedge CLK);
        end
        drain("bank_conflict");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int j = 0; j < 10; j++) begin
            #1;
            n_cmp++;
            if (wr_req_ready[3] !== 1'b1) begin
                n_err++;
                $display("FAIL stream_ready_%0d: got %b, want 1", j, wr_req_ready[3]);
            end
            put_req(3, LOG_PR_COUNT'(4 * j + 1), 32'h5EED_0000 + j, 0);
            @(negedge CLK);
        end
        wr_req_valid = '0;
        drain("back_to_back");
    endtask

    task automatic test_rr_rotation();
        do_reset();
        put_req(5, 7'd8, 32'h0000_0055, 0);
        @(negedge CLK);
        wr_req_valid = '0;
        drain("rr_first");
        put_req(6, 7'd12, 32'h0000_0066, 0);
        put_req(2, 7'd16, 32'h0000_0022, 1);
        @(negedge CLK);
        wr_req_valid = '0;
        #1;
        n_cmp++;
        if (wr_req_ready[6] !== 1'b1 || wr_req_ready[2] !== 1'b0) begin
            n_err++;
            $display("FAIL rr_ready: got r6=%b r2=%b, want r6=1 r2=0", wr_req_ready[6], wr_req_ready[2]);
        end
        drain("rr_rotation");
    endtask

    task automatic test_pr_zero();
        do_reset();
        put_req(1, 7'd0, 32'hFFFF_FFFF, 0);
        #1;
        n_cmp++;
        if (wr_req_ready[1] !== 1'b1) begin
            n_err++;
            $display("FAIL pr0_ready_before: got %b, want 1", wr_req_ready[1]);
        end
        @(negedge CLK);
        wr_req_valid = '0;
        #1;
        n_cmp++;
        if (wr_req_ready !== '1) begin
            n_err++;
            $display("FAIL pr0_not_buffered: got ready=%b, want 1111111", wr_req_ready);
        end
        drain("pr_zero");
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int i = 0; i < 4; i++) put_req(i, LOG_PR_COUNT'(3 + 4 * i), 32'hBEEF_0000 + i, i);
        @(negedge CLK);
        wr_req_valid = '0;
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        clear_q();
        n_cmp++;
        if (bank_wr_valid !== '0 || bank_wr_upper_PR !== '0 || bank_wr_data !== '0 ||
            bank_wr_src !== '0 || wr_req_ready !== '1) begin
            n_err++;
            $display("FAIL midop_reset: got valid=%b row=%h data=%h src=%h ready=%b, want 0/0/0/0/1111111",
                     bank_wr_valid, bank_wr_upper_PR, bank_wr_data, bank_wr_src, wr_req_ready);
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (6) @(negedge CLK);
        #1;
        n_cmp++;
        if (wr_req_ready !== '1) begin
            n_err++;
            $display("FAIL midop_buffers_dropped: got ready=%b, want 1111111", wr_req_ready);
        end
    endtask

    initial begin
        RST          = 1'b1;
        wr_req_valid = '0;
        wr_req_PR    = '0;
        wr_req_data  = '0;
        test_reset();
        test_four_banks();
        test_bank_conflict();
        test_back_to_back();
        test_rr_rotation();
        test_pr_zero();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_prf_wr_arbiter
`default_nettype wire
